matris_div: RTL

MATRIS_DIV -- requirements
Module: matris_div

---
 rtl/matris_pkg.sv | 21 ++
 rtl/sdiv_core.sv | 100 ++++++++++
 rtl/matris_div.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/matris_pkg.sv
// Shared widths, state encoding and saturation limits for the element-wise
// matrix divider and its iterative divider core.
package matris_pkg;

  localparam int DVD_W    = 16;
  localparam int DSR_W    = 8;
  localparam int IDX_W    = 2;
  localparam int SIZE_DEF = 2;
  localparam int ITER     = 16;
  localparam int CNT_W    = 5;

  localparam logic [DSR_W-1:0] Q_MAX = 8'h7F;
  localparam logic [DSR_W-1:0] Q_MIN = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sdiv_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// cycle, magnitudes and sign information handed back for the caller's fix-up.
module sdiv_core
  import matris_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             done,
  output logic [DSR_W-1:0] quotient,
  output logic [DSR_W-1:0] remainder,
  output logic             neg_q,
  output logic             neg_r,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] acc_q, acc_d;
  logic [DSR_W-1:0] rem_q, rem_d;
  logic [DSR_W-1:0] dsr_q, dsr_d;
  logic             sdvd_q, sdvd_d;
  logic             sdsr_q, sdsr_d;

  logic [DVD_W-1:0] dvd_mag;
  logic [DSR_W-1:0] dsr_mag;
  logic [DSR_W:0]   rem_sh;
  logic [DSR_W-1:0] rem_sub;
  logic             fits;

  // Negating -32768 in 16 bits yields 0x8000, which is the correct unsigned magnitude.
  assign dvd_mag = dividend[DVD_W-1] ? -dividend : dividend;
  assign dsr_mag = divisor[DSR_W-1]  ? -divisor  : divisor;

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    sdvd_d  = sdvd_q;
    sdsr_d  = sdsr_q;
    rem_sh  = {rem_q, acc_q[DVD_W-1]};
    rem_sub = rem_sh[DSR_W-1:0] - dsr_q;
    fits    = (rem_sh >= {1'b0, dsr_q});
    if (start && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = dvd_mag;
      rem_d  = '0;
      dsr_d  = dsr_mag;
      sdvd_d = dividend[DVD_W-1];
      sdsr_d = divisor[DSR_W-1];
    end else if (busy_q) begin
      // Dividend bits shift out of the top while quotient bits fill the bottom.
      acc_d = {acc_q[DVD_W-2:0], fits};
      rem_d = fits ? rem_sub : rem_sh[DSR_W-1:0];
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    rem_q  <= rem_d;
    dsr_q  <= dsr_d;
    sdvd_q <= sdvd_d;
    sdsr_q <= sdsr_d;
  end

  assign done      = done_q;
  assign quotient  = acc_q[DSR_W-1:0];
  assign remainder = rem_q;
  assign neg_q     = sdvd_q ^ sdsr_q;
  assign neg_r     = sdvd_q;
  // A negative result may reach magnitude 128 (-128); a positive one stops at 127.
  assign overflow  = neg_q ? (acc_q > DVD_W'(128)) : (acc_q > DVD_W'(127));

endmodule

// File: rtl/matris_div.sv
// Element-wise signed matrix divider: accepts one dividend/divisor pair at a
// time, applies sign/saturation policy and tags each result with its index.
module matris_div
  import matris_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] in_dividend,
  input  logic [DSR_W-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSR_W-1:0] out_quotient,
  output logic [DSR_W-1:0] out_remainder,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic             out_last,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [DSR_W-1:0] quot_q, quot_d;
  logic [DSR_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             last_q, last_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             zdiv_q, zdiv_d;
  logic             dneg_q, dneg_d;

  logic             core_start;
  logic             core_done;
  logic [DSR_W-1:0] core_quot;
  logic [DSR_W-1:0] core_rem;
  logic             core_negq;
  logic             core_negr;
  logic             core_ovf;
  logic             at_end;

  function automatic logic [DSR_W-1:0] fix_quot(input logic [DSR_W-1:0] mag,
                                                input logic neg, input logic ovf);
    logic [DSR_W-1:0] q;
    if (ovf) q = neg ? Q_MIN : Q_MAX;
    else     q = neg ? -mag : mag;
    return q;
  endfunction

  function automatic logic [DSR_W-1:0] fix_rem(input logic [DSR_W-1:0] mag,
                                               input logic neg, input logic ovf);
    logic [DSR_W-1:0] r;
    if (ovf) r = '0;
    else     r = neg ? -mag : mag;
    return r;
  endfunction

  sdiv_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .dividend  (in_dividend),
    .divisor   (in_divisor),
    .done      (core_done),
    .quotient  (core_quot),
    .remainder (core_rem),
    .neg_q     (core_negq),
    .neg_r     (core_negr),
    .overflow  (core_ovf)
  );

  assign at_end = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    row_d      = row_q;
    col_d      = col_q;
    last_d     = last_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    zdiv_d     = zdiv_q;
    dneg_d     = dneg_q;
    core_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // A zero divisor still spends one cycle in CALC so its result lands one edge after accept.
          zdiv_d     = (in_divisor == '0);
          dneg_d     = in_dividend[DVD_W-1];
          core_start = (in_divisor != '0);
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (zdiv_q) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          quot_d  = dneg_q ? Q_MIN : Q_MAX;
          rem_d   = '0;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          last_d  = at_end;
        end else if (core_done) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          quot_d  = fix_quot(core_quot, core_negq, core_ovf);
          rem_d   = fix_rem(core_rem, core_negr, core_ovf);
          dbz_d   = 1'b0;
          ovf_d   = core_ovf;
          last_d  = at_end;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = (row_q == LAST_IDX) ? '0 : row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    zdiv_q <= zdiv_d;
    dneg_q <= dneg_d;
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = valid_q;
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign out_row       = row_q;
  assign out_col       = col_q;
  assign out_last      = last_q;
  assign div_by_zero   = dbz_q;
  assign overflow      = ovf_q;

endmodule
